// File: rtl/mem_req_arbiter_if.sv
// Bundles the client request/response FIFO signals and the mem_ctl FIFO signals
// that the memory request arbiter sits between.
interface mem_req_arbiter_if;

   logic [2:0]   cli_valid;
   logic [5:0]   cli_cmd;
   logic [65:0]  cli_addr;
   logic [191:0] cli_dta;
   logic [2:0]   cli_rd_en;
   logic [2:0]   cli_res_almost_full;
   logic [63:0]  cli_res_dta;
   logic [2:0]   cli_res_wr_en;
   logic [1:0]   mem_req_wr_cmd;
   logic [21:0]  mem_req_wr_addr;
   logic [63:0]  mem_req_wr_dta;
   logic         mem_req_wr_en;
   logic         mem_req_wr_almost_full;
   logic         mem_res_rd_empty;
   logic         mem_res_rd_en;
   logic [63:0]  mem_res_rd_dta;
   logic         mem_res_rd_valid;
   logic         tag_error;

   // The arbiter side
   modport master (
      input  cli_valid, cli_cmd, cli_addr, cli_dta, cli_res_almost_full,
      input  mem_req_wr_almost_full, mem_res_rd_empty, mem_res_rd_dta, mem_res_rd_valid,
      output cli_rd_en, cli_res_dta, cli_res_wr_en,
      output mem_req_wr_cmd, mem_req_wr_addr, mem_req_wr_dta, mem_req_wr_en,
      output mem_res_rd_en, tag_error
   );

   // The clients plus mem_ctl side
   modport slave (
      output cli_valid, cli_cmd, cli_addr, cli_dta, cli_res_almost_full,
      output mem_req_wr_almost_full, mem_res_rd_empty, mem_res_rd_dta, mem_res_rd_valid,
      input  cli_rd_en, cli_res_dta, cli_res_wr_en,
      input  mem_req_wr_cmd, mem_req_wr_addr, mem_req_wr_dta, mem_req_wr_en,
      input  mem_res_rd_en, tag_error
   );

endinterface

// File: rtl/mem_req_arbiter.sv
// Shares the mem_ctl request/response path among three decoder clients: client 0
// has strict priority, clients 1/2 round-robin; read tags steer responses back in order.
module mem_req_arbiter #(
   parameter int TAG_DEPTH = 16,
   parameter int TAG_AW    = 4
) (
   input logic               clk,
   input logic               rst,
   mem_req_arbiter_if.master bus
);

   localparam logic [1:0] CMD_NOOP = 2'd0;
   localparam logic [1:0] CMD_READ = 2'd2;

   logic [2:0]        eligible;
   logic              grantValid;
   logic [1:0]        grantId;
   logic [1:0]        grantCmd;
   logic [21:0]       grantAddr;
   logic [63:0]       grantDta;

   logic              tagPush;
   logic              tagPop;
   logic              tagFull;
   logic              tagEmpty;
   logic [1:0]        headTag;
   logic [TAG_AW:0]   tagCount_q, tagCount_d;
   logic [TAG_AW-1:0] wrPtr_q, rdPtr_q;
   logic [1:0]        tagMem_q [TAG_DEPTH];

   logic [1:0]        rrLast_q;
   logic              popPrev_q;
   logic [1:0]        popTag_q;

   logic              reqEn_q;
   logic [1:0]        reqCmd_q;
   logic [21:0]       reqAddr_q;
   logic [63:0]       reqDta_q;
   logic [2:0]        resWrEn_q;
   logic [63:0]       resDta_q;
   logic              tagError_q;

   assign tagFull  = (tagCount_q == (TAG_AW+1)'(TAG_DEPTH));
   assign tagEmpty = (tagCount_q == '0);
   assign headTag  = tagMem_q[rdPtr_q];

   // A READ needs a free tag slot; nothing is eligible while reset is held
   always_comb begin
      for (int i = 0; i < 3; i++) begin
         eligible[i] = rst && bus.cli_valid[i] && !bus.mem_req_wr_almost_full &&
                       !((bus.cli_cmd[2*i +: 2] == CMD_READ) && tagFull);
      end
   end

   always_comb begin
      grantValid = 1'b1;
      grantId    = 2'd0;
      if (eligible[0]) begin
         grantId = 2'd0;
      end else if (eligible[1] && eligible[2]) begin
         grantId = (rrLast_q == 2'd1) ? 2'd2 : 2'd1;
      end else if (eligible[1]) begin
         grantId = 2'd1;
      end else if (eligible[2]) begin
         grantId = 2'd2;
      end else begin
         grantValid = 1'b0;
      end
   end

   always_comb begin
      case (grantId)
         2'd1: begin
            grantCmd  = bus.cli_cmd[3:2];
            grantAddr = bus.cli_addr[43:22];
            grantDta  = bus.cli_dta[127:64];
         end
         2'd2: begin
            grantCmd  = bus.cli_cmd[5:4];
            grantAddr = bus.cli_addr[65:44];
            grantDta  = bus.cli_dta[191:128];
         end
         default: begin
            grantCmd  = bus.cli_cmd[1:0];
            grantAddr = bus.cli_addr[21:0];
            grantDta  = bus.cli_dta[63:0];
         end
      endcase
   end

   // Only one response may be in flight, so a pop is never issued back-to-back
   assign tagPush = grantValid && (grantCmd == CMD_READ);
   assign tagPop  = rst && !bus.mem_res_rd_empty && !tagEmpty &&
                    !bus.cli_res_almost_full[headTag] && !popPrev_q;

   always_comb begin
      tagCount_d = tagCount_q;
      if (tagPush && !tagPop) begin
         tagCount_d = tagCount_q + 1'b1;
      end else if (!tagPush && tagPop) begin
         tagCount_d = tagCount_q - 1'b1;
      end
   end

   assign bus.cli_rd_en       = grantValid ? (3'b001 << grantId) : 3'b000;
   assign bus.mem_res_rd_en   = tagPop;
   assign bus.mem_req_wr_en   = reqEn_q;
   assign bus.mem_req_wr_cmd  = reqCmd_q;
   assign bus.mem_req_wr_addr = reqAddr_q;
   assign bus.mem_req_wr_dta  = reqDta_q;
   assign bus.cli_res_wr_en   = resWrEn_q;
   assign bus.cli_res_dta     = resDta_q;
   assign bus.tag_error       = tagError_q;

   // Tag storage needs no reset: the pointers and count define what is valid
   always_ff @(posedge clk) begin
      if (tagPush) begin
         tagMem_q[wrPtr_q] <= grantId;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         reqEn_q    <= 1'b0;
         reqCmd_q   <= '0;
         reqAddr_q  <= '0;
         reqDta_q   <= '0;
         resWrEn_q  <= '0;
         resDta_q   <= '0;
         tagError_q <= 1'b0;
         tagCount_q <= '0;
         wrPtr_q    <= '0;
         rdPtr_q    <= '0;
         rrLast_q   <= 2'd2;
         popPrev_q  <= 1'b0;
         popTag_q   <= '0;
      end else begin
         reqEn_q <= grantValid && (grantCmd != CMD_NOOP);
         if (grantValid) begin
            reqCmd_q  <= grantCmd;
            reqAddr_q <= grantAddr;
            reqDta_q  <= grantDta;
         end
         if (grantValid && (grantId != 2'd0)) begin
            rrLast_q <= grantId;
         end
         if (tagPush) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (tagPop) begin
            rdPtr_q  <= rdPtr_q + 1'b1;
            popTag_q <= headTag;
         end
         popPrev_q  <= tagPop;
         tagCount_q <= tagCount_d;
         resWrEn_q  <= 3'b000;
         // Data with no popped tag is dropped and flagged permanently
         if (bus.mem_res_rd_valid) begin
            if (popPrev_q) begin
               resWrEn_q <= 3'b001 << popTag_q;
               resDta_q  <= bus.mem_res_rd_dta;
            end else begin
               tagError_q <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_mem_req_arbiter;

   localparam int TAG_DEPTH = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   mem_req_arbiter_if bus ();

   mem_req_arbiter #(.TAG_DEPTH(TAG_DEPTH), .TAG_AW(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   int nChecks = 0;
   int nFail   = 0;

   // Reference model state
   int          rrLast = 2;
   int          tagQ[$];
   bit          popPending;
   int          popTag;
   bit          expReqEn;
   logic [1:0]  expCmd;
   logic [21:0] expAddr;
   logic [63:0] expDta;
   logic [2:0]  expResWrEn;
   logic [63:0] expResDta;
   bit          expTagError;

   typedef struct {
      logic [2:0] valid;
      logic [5:0] cmd;
      logic       af;
      logic [2:0] expRdEn;
      logic       expWrEn;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFail++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] cmdOf(int i);
      logic [5:0] c;
      c = bus.cli_cmd;
      return c[2*i +: 2];
   endfunction

   function automatic logic [21:0] addrOf(int i);
      logic [65:0] a;
      a = bus.cli_addr;
      return a[22*i +: 22];
   endfunction

   function automatic logic [63:0] dtaOf(int i);
      logic [191:0] d;
      d = bus.cli_dta;
      return d[64*i +: 64];
   endfunction

   function automatic int modelGrant();
      bit elig[3];
      if (rst == 1'b0) return -1;
      for (int i = 0; i < 3; i++) begin
         elig[i] = bus.cli_valid[i] && !bus.mem_req_wr_almost_full &&
                   !(cmdOf(i) == 2'd2 && tagQ.size() >= TAG_DEPTH);
      end
      if (elig[0]) return 0;
      if (elig[1] && elig[2]) return (rrLast == 1) ? 2 : 1;
      if (elig[1]) return 1;
      if (elig[2]) return 2;
      return -1;
   endfunction

   function automatic bit modelPop();
      if (rst == 1'b0 || bus.mem_res_rd_empty || tagQ.size() == 0 || popPending) return 1'b0;
      return !bus.cli_res_almost_full[tagQ[0]];
   endfunction

   task automatic modelAdvance(input int g, input bit p);
      if (rst == 1'b0) begin
         rrLast = 2;
         tagQ.delete();
         popPending  = 1'b0;
         popTag      = 0;
         expReqEn    = 1'b0;
         expCmd      = '0;
         expAddr     = '0;
         expDta      = '0;
         expResWrEn  = '0;
         expResDta   = '0;
         expTagError = 1'b0;
         return;
      end
      expResWrEn = 3'b000;
      if (bus.mem_res_rd_valid) begin
         if (popPending) begin
            expResWrEn = 3'(1 << popTag);
            expResDta  = bus.mem_res_rd_dta;
         end else begin
            expTagError = 1'b1;
         end
      end
      expReqEn = 1'b0;
      if (g >= 0) begin
         expReqEn = (cmdOf(g) != 2'd0);
         expCmd   = cmdOf(g);
         expAddr  = addrOf(g);
         expDta   = dtaOf(g);
         if (g != 0) rrLast = g;
      end
      popPending = p;
      if (p) popTag = tagQ.pop_front();
      if (g >= 0 && cmdOf(g) == 2'd2) tagQ.push_back(g);
   endtask

   task automatic checkOutput();
      check("mem_req_wr_en", 64'(bus.mem_req_wr_en), 64'(expReqEn));
      if (expReqEn) begin
         check("mem_req_wr_cmd", 64'(bus.mem_req_wr_cmd), 64'(expCmd));
         check("mem_req_wr_addr", 64'(bus.mem_req_wr_addr), 64'(expAddr));
         check("mem_req_wr_dta", bus.mem_req_wr_dta, expDta);
      end
      check("cli_res_wr_en", 64'(bus.cli_res_wr_en), 64'(expResWrEn));
      if (expResWrEn != 3'b000) begin
         check("cli_res_dta", bus.cli_res_dta, expResDta);
      end
      check("tag_error", 64'(bus.tag_error), 64'(expTagError));
   endtask

   // One clock cycle: inputs are already driven; mem_ctl response follows the model's pop
   task automatic applyStimulus();
      int g;
      bit p;
      #1;
      g = modelGrant();
      p = modelPop();
      check("cli_rd_en", 64'(bus.cli_rd_en), (g >= 0) ? 64'(1 << g) : 64'd0);
      check("mem_res_rd_en", 64'(bus.mem_res_rd_en), 64'(p));
      @(posedge clk);
      modelAdvance(g, p);
      #1;
      checkOutput();
      @(negedge clk);
      bus.mem_res_rd_valid = popPending;
      bus.mem_res_rd_dta   = {$urandom, $urandom};
   endtask

   task automatic setClient(input int i, input logic [1:0] cmd, input logic [21:0] addr,
                            input logic [63:0] dta);
      bus.cli_cmd[2*i +: 2]   = cmd;
      bus.cli_addr[22*i +: 22] = addr;
      bus.cli_dta[64*i +: 64]  = dta;
   endtask

   task automatic clearInputs();
      bus.cli_valid              = 3'b000;
      bus.cli_cmd                = '0;
      bus.cli_addr               = '0;
      bus.cli_dta                = '0;
      bus.cli_res_almost_full    = 3'b000;
      bus.mem_req_wr_almost_full = 1'b0;
      bus.mem_res_rd_empty       = 1'b1;
      bus.mem_res_rd_dta         = '0;
      bus.mem_res_rd_valid       = 1'b0;
   endtask

   task automatic checkResetValues();
      check("rst wr_en", 64'(bus.mem_req_wr_en), 64'd0);
      check("rst wr_cmd", 64'(bus.mem_req_wr_cmd), 64'd0);
      check("rst wr_addr", 64'(bus.mem_req_wr_addr), 64'd0);
      check("rst wr_dta", bus.mem_req_wr_dta, 64'd0);
      check("rst res_wr_en", 64'(bus.cli_res_wr_en), 64'd0);
      check("rst res_dta", bus.cli_res_dta, 64'd0);
      check("rst tag_error", 64'(bus.tag_error), 64'd0);
   endtask

   task automatic doReset();
      clearInputs();
      rst = 1'b0;
      applyStimulus();
      checkResetValues();
      bus.mem_res_rd_valid = 1'b0;
      rst = 1'b1;
   endtask

   task automatic allRead();
      for (int i = 0; i < 3; i++) setClient(i, 2'd2, 22'(32'h100 * (i + 1)), {32'hC0DE0000, 32'(i)});
   endtask

   initial begin
      logic [2:0] seq1[7];
      logic [2:0] order[$];

      vecs[0] = '{3'b000, 6'b101010, 1'b0, 3'b000, 1'b0};
      vecs[1] = '{3'b111, 6'b101010, 1'b0, 3'b001, 1'b1};
      vecs[2] = '{3'b110, 6'b101010, 1'b0, 3'b010, 1'b1};
      vecs[3] = '{3'b100, 6'b101010, 1'b0, 3'b100, 1'b1};
      vecs[4] = '{3'b111, 6'b101010, 1'b1, 3'b000, 1'b0};
      vecs[5] = '{3'b110, 6'b110000, 1'b0, 3'b010, 1'b0};
      vecs[6] = '{3'b100, 6'b110000, 1'b0, 3'b100, 1'b1};
      vecs[7] = '{3'b011, 6'b000001, 1'b0, 3'b001, 1'b1};
      seq1 = '{3'b001, 3'b001, 3'b001, 3'b010, 3'b100, 3'b010, 3'b100};

      doReset();

      // Single-cycle grant vectors, each from a fresh reset
      for (int v = 0; v < 8; v++) begin
         doReset();
         bus.cli_valid              = vecs[v].valid;
         bus.cli_cmd                = vecs[v].cmd;
         bus.cli_addr               = {22'($urandom), 22'($urandom), 22'($urandom)};
         bus.mem_req_wr_almost_full = vecs[v].af;
         #1 check($sformatf("vec%0d rd_en", v), 64'(bus.cli_rd_en), 64'(vecs[v].expRdEn));
         applyStimulus();
         check($sformatf("vec%0d wr_en", v), 64'(bus.mem_req_wr_en), 64'(vecs[v].expWrEn));
      end

      // Priority then round-robin among 1 and 2
      doReset();
      allRead();
      bus.cli_valid = 3'b111;
      for (int k = 0; k < 7; k++) begin
         if (k == 3) bus.cli_valid = 3'b110;
         #1 check($sformatf("order%0d rd_en", k), 64'(bus.cli_rd_en), 64'(seq1[k]));
         applyStimulus();
         check($sformatf("order%0d wr_en", k), 64'(bus.mem_req_wr_en), 64'd1);
      end

      // Single read round trip through client 1
      doReset();
      setClient(1, 2'd2, 22'h00100, 64'h0);
      bus.cli_valid = 3'b010;
      #1 check("rt rd_en", 64'(bus.cli_rd_en), 64'b010);
      applyStimulus();
      check("rt cmd", 64'(bus.mem_req_wr_cmd), 64'd2);
      check("rt addr", 64'(bus.mem_req_wr_addr), 64'h00100);
      bus.cli_valid        = 3'b000;
      bus.mem_res_rd_empty = 1'b0;
      #1 check("rt res_rd_en", 64'(bus.mem_res_rd_en), 64'd1);
      applyStimulus();
      bus.mem_res_rd_dta   = 64'hDEADBEEF_01234567;
      bus.mem_res_rd_empty = 1'b1;
      applyStimulus();
      check("rt res_wr_en", 64'(bus.cli_res_wr_en), 64'b010);
      check("rt res_dta", bus.cli_res_dta, 64'hDEADBEEF_01234567);

      // Tag FIFO full blocks reads but not writes
      doReset();
      allRead();
      bus.cli_valid = 3'b001;
      for (int k = 0; k < 16; k++) applyStimulus();
      setClient(2, 2'd3, 22'h3ABCD, 64'h5555AAAA_12345678);
      bus.cli_valid = 3'b101;
      #1 check("full write grant", 64'(bus.cli_rd_en), 64'b100);
      applyStimulus();
      bus.cli_valid        = 3'b001;
      bus.mem_res_rd_empty = 1'b0;
      #1 check("full read blocked", 64'(bus.cli_rd_en), 64'b000);
      check("full pop", 64'(bus.mem_res_rd_en), 64'd1);
      applyStimulus();
      bus.mem_res_rd_empty = 1'b1;
      #1 check("full read resumes", 64'(bus.cli_rd_en), 64'b001);
      applyStimulus();

      // Request FIFO backpressure
      doReset();
      allRead();
      bus.cli_valid              = 3'b111;
      bus.mem_req_wr_almost_full = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #1 check("af rd_en", 64'(bus.cli_rd_en), 64'b000);
         applyStimulus();
         check("af wr_en", 64'(bus.mem_req_wr_en), 64'd0);
      end
      bus.mem_req_wr_almost_full = 1'b0;
      #1 check("af release", 64'(bus.cli_rd_en), 64'b001);
      applyStimulus();

      // Response blocked on client 0 almost full, then in-order delivery
      doReset();
      allRead();
      for (int i = 0; i < 3; i++) begin
         bus.cli_valid = 3'(1 << i);
         applyStimulus();
      end
      bus.cli_valid           = 3'b000;
      bus.mem_res_rd_empty    = 1'b0;
      bus.cli_res_almost_full = 3'b001;
      for (int k = 0; k < 4; k++) begin
         #1 check("hol no pop", 64'(bus.mem_res_rd_en), 64'd0);
         applyStimulus();
      end
      bus.cli_res_almost_full = 3'b000;
      for (int k = 0; k < 8; k++) begin
         applyStimulus();
         if (bus.cli_res_wr_en != 3'b000) order.push_back(bus.cli_res_wr_en);
      end
      check("hol count", 64'(order.size()), 64'd3);
      if (order.size() == 3) begin
         check("hol first", 64'(order[0]), 64'b001);
         check("hol second", 64'(order[1]), 64'b010);
         check("hol third", 64'(order[2]), 64'b100);
      end

      // Stray response data, then reset in the middle of traffic
      doReset();
      bus.mem_res_rd_valid = 1'b1;
      applyStimulus();
      check("stray tag_error", 64'(bus.tag_error), 64'd1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus();
         check("sticky tag_error", 64'(bus.tag_error), 64'd1);
      end
      allRead();
      bus.cli_valid        = 3'b111;
      bus.mem_res_rd_empty = 1'b0;
      for (int k = 0; k < 6; k++) applyStimulus();
      rst = 1'b0;
      #1 check("midrst rd_en", 64'(bus.cli_rd_en), 64'd0);
      check("midrst res_rd_en", 64'(bus.mem_res_rd_en), 64'd0);
      applyStimulus();
      checkResetValues();
      rst = 1'b1;

      // Randomized traffic against the model
      doReset();
      for (int c = 0; c < 3000; c++) begin
         rst                        = ($urandom_range(399) != 0);
         bus.cli_valid              = 3'($urandom);
         for (int i = 0; i < 3; i++) setClient(i, 2'($urandom), 22'($urandom), {$urandom, $urandom});
         bus.mem_req_wr_almost_full = ($urandom_range(7) == 0);
         bus.mem_res_rd_empty       = ($urandom_range(2) == 0);
         for (int i = 0; i < 3; i++) bus.cli_res_almost_full[i] = ($urandom_range(5) == 0);
         applyStimulus();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
      $finish;
   end

endmodule
